// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: tracks EX/MEM destination shadows, raises load-use and
// branch-operand stalls, flushes IF/ID on a taken BEQ, and counts stall cycles.
module hazard_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    input  logic [5:0]  id_opcode,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [4:0]  id_rd,
    input  logic        branch_taken,
    output logic        hazard_detected,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        ifid_flush,
    output logic [15:0] stall_cnt
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    logic       reads_rs;
    logic       reads_rt;
    logic       writes;
    logic       memread;
    logic       is_beq;
    logic [4:0] dec_dst;

    logic [4:0] ex_dst;
    logic       ex_rw;
    logic       ex_mr;
    logic [4:0] mem_dst;
    logic       mem_rw;
    logic       mem_mr;

    logic       ex_match;
    logic       mem_match;
    logic       load_use;
    logic       branch_alu;
    logic       branch_load;
    logic       issue;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic dst_match(input logic [4:0] dst, input logic valid,
                                       input logic [4:0] rs, input logic use_rs,
                                       input logic [4:0] rt, input logic use_rt);
        return valid && (dst != 5'd0) &&
               ((use_rs && (dst == rs)) || (use_rt && (dst == rt)));
    endfunction

    always_comb begin
        reads_rs = 1'b0;
        reads_rt = 1'b0;
        writes   = 1'b0;
        memread  = 1'b0;
        dec_dst  = 5'd0;
        unique case (id_opcode)
            OP_LW: begin
                reads_rs = 1'b1;
                writes   = 1'b1;
                memread  = 1'b1;
                dec_dst  = id_rt;
            end
            OP_SW: begin
                reads_rs = 1'b1;
                reads_rt = 1'b1;
            end
            OP_ADDI: begin
                reads_rs = 1'b1;
                writes   = 1'b1;
                dec_dst  = id_rt;
            end
            OP_BEQ: begin
                reads_rs = 1'b1;
                reads_rt = 1'b1;
            end
            OP_RTYPE: begin
                reads_rs = 1'b1;
                reads_rt = 1'b1;
                writes   = 1'b1;
                dec_dst  = id_rd;
            end
            default: ;
        endcase
    end

    assign is_beq = (id_opcode == OP_BEQ);

    always_comb begin
        ex_match    = dst_match(ex_dst, id_valid, id_rs, reads_rs, id_rt, reads_rt);
        mem_match   = dst_match(mem_dst, id_valid, id_rs, reads_rs, id_rt, reads_rt);
        load_use    = ex_mr && ex_match;
        branch_alu  = is_beq && ex_rw && !ex_mr && ex_match;
        // mr is only ever set together with rw, so requiring both is equivalent
        branch_load = is_beq && mem_rw && mem_mr && mem_match;
    end

    assign hazard_detected = load_use || branch_alu || branch_load;
    assign pc_write        = !hazard_detected;
    assign ifid_write      = !hazard_detected;
    assign ifid_flush      = id_valid && is_beq && branch_taken && !hazard_detected;
    assign issue           = id_valid && !hazard_detected;

    // EX/MEM shadow advance; a stalled or empty ID slot enters EX as a bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_dst    <= 5'd0;
            ex_rw     <= 1'b0;
            ex_mr     <= 1'b0;
            mem_dst   <= 5'd0;
            mem_rw    <= 1'b0;
            mem_mr    <= 1'b0;
            stall_cnt <= 16'd0;
        end else begin
            mem_dst <= ex_dst;
            mem_rw  <= ex_rw;
            mem_mr  <= ex_mr;
            ex_dst  <= issue ? dec_dst : 5'd0;
            ex_rw   <= issue ? writes  : 1'b0;
            ex_mr   <= issue ? memread : 1'b0;
            if (hazard_detected) begin
                stall_cnt <= sat_inc(stall_cnt);
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed and randomized bench for hazard_ctrl against an instruction-history
// reference model (register read masks and the two most recently issued instructions).
module tb_hazard_ctrl;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_XX   = 6'b111111;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic [5:0]  id_opcode;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [4:0]  id_rd;
    logic        branch_taken;
    logic        hazard_detected;
    logic        pc_write;
    logic        ifid_write;
    logic        ifid_flush;
    logic [15:0] stall_cnt;

    hazard_ctrl dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .branch_taken(branch_taken),
        .hazard_detected(hazard_detected), .pc_write(pc_write), .ifid_write(ifid_write),
        .ifid_flush(ifid_flush), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       load;
        logic       wr;
        logic [4:0] dst;
    } rec_t;

    localparam rec_t BUBBLE = '{load: 1'b0, wr: 1'b0, dst: 5'd0};

    rec_t        prev1;
    rec_t        prev2;
    int          model_cnt;
    int          errors;
    int          checks;
    logic        obs_hz;
    logic        obs_fl;

    function automatic logic [31:0] read_mask(input logic [5:0] op, input logic [4:0] rs,
                                              input logic [4:0] rt);
        logic [31:0] m;
        case (op)
            OP_LW, OP_ADDI:     m = 32'h1 << rs;
            OP_SW, OP_BEQ, OP_R: m = (32'h1 << rs) | (32'h1 << rt);
            default:            m = 32'h0;
        endcase
        return m & ~32'h1;
    endfunction

    function automatic rec_t decode(input logic [5:0] op, input logic [4:0] rt,
                                    input logic [4:0] rd);
        rec_t r;
        r = BUBBLE;
        case (op)
            OP_LW:   r = '{load: 1'b1, wr: 1'b1, dst: rt};
            OP_ADDI: r = '{load: 1'b0, wr: 1'b1, dst: rt};
            OP_R:    r = '{load: 1'b0, wr: 1'b1, dst: rd};
            default: r = BUBBLE;
        endcase
        return r;
    endfunction

    function automatic logic model_hazard(input logic v, input logic [5:0] op,
                                          input logic [4:0] rs, input logic [4:0] rt);
        logic [31:0] m;
        logic        beq;
        if (!v) return 1'b0;
        m   = read_mask(op, rs, rt);
        beq = (op == OP_BEQ);
        return (prev1.wr && prev1.load && m[prev1.dst]) ||
               (beq && prev1.wr && !prev1.load && m[prev1.dst]) ||
               (beq && prev2.load && m[prev2.dst]);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1; drives ID, checks combinational outputs, then clocks once.
    task automatic step(input logic v, input logic [5:0] op, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] rd, input logic bt,
                        input logic chk);
        logic exp_hz;
        logic exp_fl;
        id_valid = v; id_opcode = op; id_rs = rs; id_rt = rt; id_rd = rd; branch_taken = bt;
        #1;
        exp_hz = model_hazard(v, op, rs, rt);
        exp_fl = v && (op == OP_BEQ) && bt && !exp_hz;
        obs_hz = hazard_detected;
        obs_fl = ifid_flush;
        if (chk) begin
            check("hazard", {31'd0, hazard_detected}, {31'd0, exp_hz});
            check("pc_write", {31'd0, pc_write}, {31'd0, !exp_hz});
            check("ifid_write", {31'd0, ifid_write}, {31'd0, !exp_hz});
            check("ifid_flush", {31'd0, ifid_flush}, {31'd0, exp_fl});
        end
        @(posedge clk);
        prev2 = prev1;
        prev1 = (v && !exp_hz) ? decode(op, rt, rd) : BUBBLE;
        if (exp_hz && model_cnt < 65535) model_cnt++;
        #1;
        if (chk) check("stall_cnt", {16'd0, stall_cnt}, model_cnt);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        id_valid = 1'b0; id_opcode = OP_XX; id_rs = 5'd0; id_rt = 5'd0; id_rd = 5'd0;
        branch_taken = 1'b0;
        #1;
        prev1 = BUBBLE; prev2 = BUBBLE; model_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [5:0] rop;
        errors = 0; checks = 0;
        prev1 = BUBBLE; prev2 = BUBBLE; model_cnt = 0;

        rst_n = 1'b0;
        id_valid = 1'b1; id_opcode = OP_BEQ; id_rs = 5'd1; id_rt = 5'd1; id_rd = 5'd0;
        branch_taken = 1'b1;
        #2;
        check("rst_hazard", {31'd0, hazard_detected}, 32'd0);
        check("rst_pc_write", {31'd0, pc_write}, 32'd1);
        check("rst_ifid_write", {31'd0, ifid_write}, 32'd1);
        check("rst_flush", {31'd0, ifid_flush}, 32'd1);
        check("rst_cnt", {16'd0, stall_cnt}, 32'd0);

        // LW $2,0($1) ; ADD $3,$2,$4
        do_reset();
        step(1'b1, OP_LW, 5'd1, 5'd2, 5'd0, 1'b0, 1'b1);
        step(1'b1, OP_R, 5'd2, 5'd4, 5'd3, 1'b0, 1'b1);
        check("lw_add_stall", {31'd0, obs_hz}, 32'd1);
        step(1'b1, OP_R, 5'd2, 5'd4, 5'd3, 1'b0, 1'b1);
        check("lw_add_cnt", {16'd0, stall_cnt}, 32'd1);

        // LW $2 ; BEQ $2,$5
        do_reset();
        step(1'b1, OP_LW, 5'd1, 5'd2, 5'd0, 1'b0, 1'b1);
        step(1'b1, OP_BEQ, 5'd2, 5'd5, 5'd0, 1'b0, 1'b1);
        step(1'b1, OP_BEQ, 5'd2, 5'd5, 5'd0, 1'b0, 1'b1);
        check("lw_beq_2nd", {31'd0, obs_hz}, 32'd1);
        step(1'b1, OP_BEQ, 5'd2, 5'd5, 5'd0, 1'b0, 1'b1);
        check("lw_beq_clear", {31'd0, obs_hz}, 32'd0);
        check("lw_beq_cnt", {16'd0, stall_cnt}, 32'd2);

        // ADD $6,$1,$1 ; BEQ $6,$0  then  ADD $6 ; SW $6
        do_reset();
        step(1'b1, OP_R, 5'd1, 5'd1, 5'd6, 1'b0, 1'b1);
        step(1'b1, OP_BEQ, 5'd6, 5'd0, 5'd0, 1'b0, 1'b1);
        step(1'b1, OP_BEQ, 5'd6, 5'd0, 5'd0, 1'b0, 1'b1);
        check("add_beq_cnt", {16'd0, stall_cnt}, 32'd1);
        do_reset();
        step(1'b1, OP_R, 5'd1, 5'd1, 5'd6, 1'b0, 1'b1);
        step(1'b1, OP_SW, 5'd1, 5'd6, 5'd0, 1'b0, 1'b1);
        check("add_sw_cnt", {16'd0, stall_cnt}, 32'd0);

        // register 0 and invalid ID never match
        do_reset();
        step(1'b1, OP_LW, 5'd1, 5'd0, 5'd0, 1'b0, 1'b1);
        step(1'b1, OP_R, 5'd0, 5'd0, 5'd3, 1'b0, 1'b1);
        step(1'b1, OP_LW, 5'd1, 5'd2, 5'd0, 1'b0, 1'b1);
        step(1'b0, OP_R, 5'd2, 5'd2, 5'd3, 1'b0, 1'b1);
        check("zero_invalid_cnt", {16'd0, stall_cnt}, 32'd0);

        // taken-branch flush, suppressed while stalled
        do_reset();
        step(1'b1, OP_BEQ, 5'd1, 5'd1, 5'd0, 1'b1, 1'b1);
        check("beq_flush", {31'd0, obs_fl}, 32'd1);
        step(1'b1, OP_LW, 5'd1, 5'd2, 5'd0, 1'b0, 1'b1);
        step(1'b1, OP_BEQ, 5'd2, 5'd5, 5'd0, 1'b1, 1'b1);
        check("stall_noflush1", {31'd0, obs_fl}, 32'd0);
        step(1'b1, OP_BEQ, 5'd2, 5'd5, 5'd0, 1'b1, 1'b1);
        check("stall_noflush2", {31'd0, obs_fl}, 32'd0);
        step(1'b1, OP_BEQ, 5'd2, 5'd5, 5'd0, 1'b1, 1'b1);
        check("flush_after_stall", {31'd0, obs_fl}, 32'd1);

        // randomized mix on a small register window
        do_reset();
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 5))
                0: rop = OP_LW;
                1: rop = OP_SW;
                2: rop = OP_ADDI;
                3: rop = OP_BEQ;
                4: rop = OP_R;
                default: rop = OP_XX;
            endcase
            step(($urandom_range(0, 7) != 0), rop, 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 1'b1);
        end

        // saturation: two stalls per three-cycle group, 65540 stalls in total
        do_reset();
        for (int g = 0; g < 32770; g++) begin
            step(1'b1, OP_LW, 5'd2, 5'd2, 5'd0, 1'b0, 1'b0);
            step(1'b1, OP_BEQ, 5'd2, 5'd2, 5'd0, 1'b0, 1'b0);
            step(1'b1, OP_BEQ, 5'd2, 5'd2, 5'd0, 1'b0, 1'b0);
        end
        check("sat_cnt", {16'd0, stall_cnt}, 32'h0000FFFF);
        check("sat_model", {16'd0, stall_cnt}, model_cnt);

        // reset asserted in the middle of a stall
        step(1'b1, OP_LW, 5'd1, 5'd2, 5'd0, 1'b0, 1'b1);
        id_valid = 1'b1; id_opcode = OP_BEQ; id_rs = 5'd2; id_rt = 5'd5; branch_taken = 1'b0;
        #1;
        check("mid_stall_hz", {31'd0, hazard_detected}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_cancel_hz", {31'd0, hazard_detected}, 32'd0);
        check("rst_cancel_pc", {31'd0, pc_write}, 32'd1);
        check("rst_cancel_cnt", {16'd0, stall_cnt}, 32'd0);
        do_reset();
        step(1'b1, OP_R, 5'd2, 5'd4, 5'd3, 1'b0, 1'b1);
        check("post_rst_nohz", {31'd0, obs_hz}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
